// File: rtl/ula_seq_if.sv
// Handshake/operand bus for ula_seq.
// The master side is the operand source plus the result sink; the slave side is the ALU.
interface ula_seq_if #(
  parameter int NBITS = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] B;
  logic [2:0]       F;
  logic             use_acc;
  logic             clr_sticky;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] Saida;
  logic             FLAG_O;
  logic             FLAG_Z;
  logic             FLAG_N;
  logic             FLAG_OS;

  modport master (
    output in_valid, A, B, F, use_acc, clr_sticky, out_ready,
    input  in_ready, out_valid, Saida, FLAG_O, FLAG_Z, FLAG_N, FLAG_OS
  );

  modport slave (
    input  in_valid, A, B, F, use_acc, clr_sticky, out_ready,
    output in_ready, out_valid, Saida, FLAG_O, FLAG_Z, FLAG_N, FLAG_OS
  );
endinterface

// File: rtl/ula_seq.sv
// Sequential signed ALU with valid/ready handshake, an iterative shift-add multiplier,
// an accumulator operand mode and Z/N/overflow/sticky-overflow flags.
// Only one operation is in flight at a time: IDLE accepts, MUL iterates, HOLD presents the result.
module ula_seq #(
  parameter int NBITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  ula_seq_if.slave   bus
);

  localparam int MSB = NBITS - 1;
  localparam int CW  = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  state_t           state;
  logic [NBITS-1:0] acc;
  logic [NBITS-1:0] saida_q;
  logic             o_q;
  logic             z_q;
  logic             n_q;
  logic             os_q;
  logic             out_valid_q;

  // Multiplier state: running product, left-shifting multiplicand, right-shifting multiplier
  logic [2*NBITS-1:0] prod;
  logic [2*NBITS-1:0] mcand;
  logic [NBITS-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [NBITS-1:0] op_a;
  logic [NBITS-1:0] op_b;
  logic [NBITS-1:0] sum;
  logic [NBITS-1:0] diff;
  logic [NBITS-1:0] alu_res;
  logic             alu_ovf;

  logic [2*NBITS-1:0] term;
  logic [2*NBITS-1:0] prod_next;
  logic [NBITS:0]     prod_top;
  logic               mul_ovf;

  // Single-cycle operations evaluated straight from the bus so the result registers on the accept edge
  always_comb begin
    op_a    = bus.use_acc ? acc : bus.A;
    op_b    = bus.B;
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.F)
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLT: alu_res = {{(NBITS-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SRA: alu_res = $signed(op_a) >>> op_b[CW-1:0];
      default: alu_res = '0;
    endcase
  end

  // One partial product per cycle; the multiplier MSB carries negative weight, so it is subtracted
  always_comb begin
    term = '0;
    if (mplier[0]) begin
      term = (cnt == LAST) ? -mcand : mcand;
    end
    prod_next = prod + term;
    prod_top  = prod_next[2*NBITS-1:NBITS-1];
    mul_ovf   = !((&prod_top) || (~|prod_top));
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.Saida     = saida_q;
  assign bus.FLAG_O    = o_q;
  assign bus.FLAG_Z    = z_q;
  assign bus.FLAG_N    = n_q;
  assign bus.FLAG_OS   = os_q;

  // Control FSM with registered result, flags, accumulator and multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      saida_q     <= '0;
      o_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      os_q        <= 1'b0;
      out_valid_q <= 1'b0;
      prod        <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
    end else begin
      // A clear request is applied first so that an overflowing handoff in the same cycle still sets
      os_q <= os_q & ~bus.clr_sticky;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.F == OP_MUL) begin
              prod   <= '0;
              mcand  <= {{NBITS{op_a[MSB]}}, op_a};
              mplier <= op_b;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              saida_q     <= alu_res;
              o_q         <= alu_ovf;
              z_q         <= (alu_res == '0);
              n_q         <= alu_res[MSB];
              out_valid_q <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            saida_q     <= prod_next[NBITS-1:0];
            o_q         <= mul_ovf;
            z_q         <= (prod_next[NBITS-1:0] == '0);
            n_q         <= prod_next[NBITS-1];
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc         <= saida_q;
            out_valid_q <= 1'b0;
            state       <= IDLE;
            if (o_q) begin
              os_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (NBITS=8): scoreboard of expected results from a
// small integer-arithmetic model, plus latency, stall, accumulator, sticky and reset checks.
module tb_ula_seq;

  localparam int NBITS = 8;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef struct packed {
    logic [7:0] saida;
    logic       o;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   numCompared;
  int   numMismatched;
  logic [7:0] modelAcc;
  logic       modelOs;

  ula_seq_if #(.NBITS(NBITS)) bus();

  ula_seq #(.NBITS(NBITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case a bounded wait is ever miscounted
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    numCompared++;
    if (got !== expv) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference model using plain integer arithmetic and range tests for overflow
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    exp_t e;
    int   sa;
    int   sbv;
    int   r;
    sa  = $signed(a);
    sbv = $signed(b);
    r   = 0;
    e.o = 1'b0;
    e.saida = 8'h00;
    case (f)
      OP_AND: e.saida = a & b;
      OP_OR:  e.saida = a | b;
      OP_XOR: e.saida = a ^ b;
      OP_ADD, OP_SUB, OP_MUL: begin
        if (f == OP_ADD)      r = sa + sbv;
        else if (f == OP_SUB) r = sa - sbv;
        else                  r = sa * sbv;
        e.saida = r[7:0];
        e.o     = (r > 127) || (r < -128);
      end
      OP_SLT: e.saida = (sa < sbv) ? 8'd1 : 8'd0;
      default: begin
        r = sa >>> b[2:0];
        e.saida = r[7:0];
      end
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f, input logic useAcc);
    int waited;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    bus.A       = a;
    bus.B       = b;
    bus.F       = f;
    bus.use_acc = useAcc;
    bus.in_valid = 1'b1;
    sb.push_back(model(useAcc ? modelAcc : a, b, f));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.use_acc  = 1'b0;
  endtask

  task automatic collectResult(input int expLat, input int stallCycles, input logic clr);
    exp_t e;
    int   lat;
    int   readyHigh;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    lat = 1;
    readyHigh = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready === 1'b1) readyHigh++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      checkOutput("result_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("busy_in_ready", readyHigh, 0);
    checkOutput("saida", bus.Saida, e.saida);
    checkOutput("flag_o", bus.FLAG_O, e.o);
    checkOutput("flag_z", bus.FLAG_Z, (e.saida == 8'h00));
    checkOutput("flag_n", bus.FLAG_N, e.saida[7]);
    // Hold the sink off while a competing request is presented; nothing may move
    if (stallCycles > 0) begin
      bus.A = 8'h11;
      bus.B = 8'h22;
      bus.F = OP_ADD;
      bus.in_valid = 1'b1;
      for (int i = 0; i < stallCycles; i++) begin
        @(posedge clk);
        #1;
        checkOutput("stall_valid", bus.out_valid, 1'b1);
        checkOutput("stall_in_ready", bus.in_ready, 1'b0);
        checkOutput("stall_saida", bus.Saida, e.saida);
        checkOutput("stall_flags", {bus.FLAG_O, bus.FLAG_Z, bus.FLAG_N}, {e.o, (e.saida == 8'h00), e.saida[7]});
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready  = 1'b1;
    bus.clr_sticky = clr;
    @(posedge clk);
    #1;
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    modelAcc = e.saida;
    modelOs  = (modelOs & ~clr) | e.o;
    checkOutput("handoff_valid", bus.out_valid, 1'b0);
    checkOutput("idle_in_ready", bus.in_ready, 1'b1);
    checkOutput("sticky", bus.FLAG_OS, modelOs);
  endtask

  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                       input logic useAcc, input int stallCycles, input logic clr);
    applyStimulus(a, b, f, useAcc);
    collectResult((f == OP_MUL) ? NBITS + 1 : 1, stallCycles, clr);
  endtask

  // Main sequence
  initial begin
    numCompared   = 0;
    numMismatched = 0;
    modelAcc      = 8'h00;
    modelOs       = 1'b0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.A          = 8'h00;
    bus.B          = 8'h00;
    bus.F          = 3'b000;
    bus.use_acc    = 1'b0;
    bus.clr_sticky = 1'b0;
    bus.out_ready  = 1'b0;
    #12;
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_saida", bus.Saida, 8'h00);
    checkOutput("rst_flags", {bus.FLAG_O, bus.FLAG_Z, bus.FLAG_N, bus.FLAG_OS}, 4'b0000);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Overflowing add, then signed boundary cases; the zero add also clears the sticky flag
    runOp(8'd100, 8'd50, OP_ADD, 1'b0, 0, 1'b0);
    runOp(8'h80, 8'd1, OP_SUB, 1'b0, 0, 1'b0);
    runOp(8'h00, 8'h80, OP_SUB, 1'b0, 0, 1'b0);
    runOp(8'h00, 8'h00, OP_ADD, 1'b0, 0, 1'b1);

    // Multiplies including the most-negative operand cases
    runOp(8'hF9, 8'd9, OP_MUL, 1'b0, 0, 1'b0);
    runOp(8'd16, 8'd8, OP_MUL, 1'b0, 0, 1'b0);
    runOp(8'hF0, 8'd8, OP_MUL, 1'b0, 0, 1'b0);
    runOp(8'h80, 8'h80, OP_MUL, 1'b0, 0, 1'b0);
    runOp(8'd5, 8'h80, OP_MUL, 1'b0, 0, 1'b0);
    runOp(8'hFF, 8'h80, OP_MUL, 1'b0, 0, 1'b1);

    // Sink back-pressure with an intruding request
    runOp(8'd1, 8'd2, OP_ADD, 1'b0, 5, 1'b0);

    // Accumulator chain and bitwise ops
    runOp(8'd5, 8'd3, OP_ADD, 1'b0, 0, 1'b0);
    runOp(8'hAA, 8'd2, OP_ADD, 1'b1, 0, 1'b0);
    runOp(8'h00, 8'd1, OP_SRA, 1'b1, 0, 1'b0);
    runOp(8'h7F, 8'd6, OP_SLT, 1'b1, 0, 1'b0);
    runOp(8'hC3, 8'h5A, OP_AND, 1'b0, 0, 1'b0);
    runOp(8'hC3, 8'h5A, OP_OR, 1'b0, 0, 1'b0);
    runOp(8'hC3, 8'h5A, OP_XOR, 1'b0, 0, 1'b0);
    runOp(8'h90, 8'h0B, OP_SRA, 1'b0, 0, 1'b0);

    // Random mix of operations, operand modes and clears
    for (int i = 0; i < 24; i++) begin
      runOp(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 0, ($urandom_range(0, 3) == 0));
    end

    // Clear concurrent with an overflowing handoff: set must win
    runOp(8'd127, 8'd1, OP_ADD, 1'b0, 0, 1'b1);

    // Reset in the middle of a multiply discards it and clears accumulator and sticky flag
    applyStimulus(8'hF9, 8'd9, OP_MUL, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
    checkOutput("midrst_sticky", bus.FLAG_OS, 1'b0);
    checkOutput("midrst_saida", bus.Saida, 8'h00);
    sb.delete();
    modelAcc = 8'h00;
    modelOs  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_in_ready", bus.in_ready, 1'b1);
    runOp(8'h55, 8'd7, OP_ADD, 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
